// File: rtl/vdp_cpu_port.sv
// CPU side of the MSX VDP: decodes Z80 accesses to ports 98h/99h, drives VRAM writes and
// read-ahead prefetches, and holds R0-R7 plus status for the display block.
module vdp_cpu_port #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  // cpu_sel is a single-cycle strobe qualified by cpu_wr/cpu_a0; strobes arrive at least two
  // cycles apart, and cpu_dout is valid from the cycle after a read strobe until the next read.
  input  logic              cpu_sel,
  input  logic              cpu_wr,
  input  logic              cpu_a0,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_din,
  output logic              vram_wr,
  output logic              vram_rd,
  input  logic [7:0]        vram_dout,
  input  logic              frame_int,
  input  logic              sprite_collision,
  input  logic              too_many_sprites,
  input  logic [4:0]        sprite5,
  output logic [1:0]        mode,
  output logic [13:0]       name_table_addr,
  output logic [13:0]       color_table_addr,
  output logic [13:0]       font_table_addr,
  output logic [13:0]       sprite_attr_table_addr,
  output logic [13:0]       sprite_pattern_table_addr,
  output logic              video_on,
  output logic              sprite_large,
  output logic              sprite_enlarged,
  output logic              vert_retrace_int,
  output logic [3:0]        text_color,
  output logic [3:0]        back_color,
  output logic              n_int
);

  // Only the register bits the display block consumes are stored.
  logic              r0_m3;
  logic              r1_vid, r1_ie, r1_m1, r1_m2, r1_size, r1_mag;
  logic [3:0]        r2;
  logic [7:0]        r3;
  logic [2:0]        r4;
  logic [6:0]        r5;
  logic [2:0]        r6;
  logic [7:0]        r7;

  logic              latch_full;
  logic [7:0]        latch_byte;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        rd_buf;
  logic              capture;
  logic              stat_f, stat_c, stat_5s;
  logic [4:0]        sprite5_latched;
  logic              tms_q;

  logic              data_acc, ctrl_wr, stat_rd, tms_rise;
  logic [ADDR_W-1:0] ctrl_addr;

  assign data_acc  = cpu_sel && !cpu_a0;
  assign ctrl_wr   = cpu_sel && cpu_a0 && cpu_wr;
  assign stat_rd   = cpu_sel && cpu_a0 && !cpu_wr;
  assign tms_rise  = too_many_sprites && !tms_q;
  assign ctrl_addr = ADDR_W'({cpu_din[5:0], latch_byte});

  always_ff @(posedge clk) begin
    if (reset) begin
      r0_m3 <= 1'b0;
      {r1_vid, r1_ie, r1_m1, r1_m2, r1_size, r1_mag} <= '0;
      r2 <= '0; r3 <= '0; r4 <= '0; r5 <= '0; r6 <= '0; r7 <= '0;
      latch_full      <= 1'b0;
      latch_byte      <= '0;
      addr            <= '0;
      rd_buf          <= '0;
      capture         <= 1'b0;
      cpu_dout        <= '0;
      vram_addr       <= '0;
      vram_din        <= '0;
      vram_wr         <= 1'b0;
      vram_rd         <= 1'b0;
      stat_f          <= 1'b0;
      stat_c          <= 1'b0;
      stat_5s         <= 1'b0;
      sprite5_latched <= '0;
      tms_q           <= 1'b0;
    end else begin
      vram_wr <= 1'b0;
      vram_rd <= 1'b0;
      // VRAM returns data the cycle after vram_rd; addr was already advanced at issue.
      capture <= vram_rd;
      if (capture) rd_buf <= vram_dout;

      if (data_acc || stat_rd) latch_full <= 1'b0;

      if (ctrl_wr) begin
        if (!latch_full) begin
          latch_byte <= cpu_din;
          latch_full <= 1'b1;
        end else begin
          latch_full <= 1'b0;
          if (cpu_din[7]) begin
            case (cpu_din[2:0])
              3'd0: r0_m3 <= latch_byte[1];
              3'd1: {r1_vid, r1_ie, r1_m1, r1_m2, r1_size, r1_mag} <=
                      {latch_byte[6:3], latch_byte[1:0]};
              3'd2: r2 <= latch_byte[3:0];
              3'd3: r3 <= latch_byte;
              3'd4: r4 <= latch_byte[2:0];
              3'd5: r5 <= latch_byte[6:0];
              3'd6: r6 <= latch_byte[2:0];
              default: r7 <= latch_byte;
            endcase
          end else if (cpu_din[6]) begin
            addr <= ctrl_addr;
          end else begin
            vram_rd   <= 1'b1;
            vram_addr <= ctrl_addr;
            addr      <= ctrl_addr + 1'b1;
          end
        end
      end

      if (data_acc && cpu_wr) begin
        vram_wr   <= 1'b1;
        vram_addr <= addr;
        vram_din  <= cpu_din;
        rd_buf    <= cpu_din;
        addr      <= addr + 1'b1;
      end

      if (data_acc && !cpu_wr) begin
        // A read landing on the capture cycle takes the prefetched byte straight from VRAM.
        cpu_dout  <= capture ? vram_dout : rd_buf;
        vram_rd   <= 1'b1;
        vram_addr <= addr;
        addr      <= addr + 1'b1;
      end

      if (stat_rd) cpu_dout <= {stat_f, stat_5s, stat_c, sprite5_latched};

      // A set in the same cycle as a clearing status read wins.
      stat_f <= frame_int || (stat_f && !stat_rd);
      stat_c <= sprite_collision || (stat_c && !stat_rd);
      tms_q  <= too_many_sprites;
      if (tms_rise) begin
        stat_5s <= 1'b1;
        if (!stat_5s) sprite5_latched <= sprite5;
      end else if (stat_rd) begin
        stat_5s <= 1'b0;
      end
    end
  end

  always_comb begin
    mode = 2'd1;
    if (r1_m1)      mode = 2'd0;
    else if (r0_m3) mode = 2'd2;
    else if (r1_m2) mode = 2'd3;
  end

  assign name_table_addr           = {r2, 10'b0};
  assign color_table_addr          = (mode == 2'd2) ? {r3[7], 13'b0} : {r3, 6'b0};
  assign font_table_addr           = (mode == 2'd2) ? {r4[2], 13'b0} : {r4, 11'b0};
  assign sprite_attr_table_addr    = {r5, 7'b0};
  assign sprite_pattern_table_addr = {r6, 11'b0};
  assign video_on                  = r1_vid;
  assign vert_retrace_int          = r1_ie;
  assign sprite_large              = r1_size;
  assign sprite_enlarged           = r1_mag;
  assign text_color                = r7[7:4];
  assign back_color                = r7[3:0];
  assign n_int                     = !(stat_f && r1_ie);

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: a behavioural VDP model predicts VRAM pulses and CPU read data into a
// queue that a negedge monitor drains; register-derived outputs are compared against the model.
module tb_vdp_cpu_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_sel = 1'b0, cpu_wr = 1'b0, cpu_a0 = 1'b0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic [13:0] vram_addr;
  logic [7:0]  vram_din;
  logic        vram_wr, vram_rd;
  logic [7:0]  vram_dout;
  logic        frame_int = 1'b0, sprite_collision = 1'b0, too_many_sprites = 1'b0;
  logic [4:0]  sprite5 = '0;
  logic [1:0]  mode;
  logic [13:0] name_table_addr, color_table_addr, font_table_addr;
  logic [13:0] sprite_attr_table_addr, sprite_pattern_table_addr;
  logic        video_on, sprite_large, sprite_enlarged, vert_retrace_int, n_int;
  logic [3:0]  text_color, back_color;

  always #5 clk = ~clk;

  vdp_cpu_port #(.ADDR_W(14)) dut (
    .clk(clk), .reset(reset),
    .cpu_sel(cpu_sel), .cpu_wr(cpu_wr), .cpu_a0(cpu_a0), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .vram_addr(vram_addr), .vram_din(vram_din), .vram_wr(vram_wr), .vram_rd(vram_rd),
    .vram_dout(vram_dout),
    .frame_int(frame_int), .sprite_collision(sprite_collision),
    .too_many_sprites(too_many_sprites), .sprite5(sprite5),
    .mode(mode), .name_table_addr(name_table_addr), .color_table_addr(color_table_addr),
    .font_table_addr(font_table_addr), .sprite_attr_table_addr(sprite_attr_table_addr),
    .sprite_pattern_table_addr(sprite_pattern_table_addr),
    .video_on(video_on), .sprite_large(sprite_large), .sprite_enlarged(sprite_enlarged),
    .vert_retrace_int(vert_retrace_int), .text_color(text_color), .back_color(back_color),
    .n_int(n_int)
  );

  // VRAM environment: synchronous memory, read data valid the cycle after vram_rd.
  logic [7:0] vmem [0:16383];
  always @(posedge clk) begin
    if (vram_wr) vmem[vram_addr] <= vram_din;
    if (vram_rd) vram_dout <= vmem[vram_addr];
  end

  // Scoreboard: {kind[1:0], addr[13:0], data[7:0]}; kind 1=vram_wr, 2=vram_rd, 3=cpu_dout.
  logic [23:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic mon_pop(input string nm, input logic [23:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got %0h, expected no event at %0t", nm, act, $time);
    end else begin
      chk(nm, {8'h0, act}, {8'h0, exp_q.pop_front()});
    end
  endtask

  logic rd_due = 1'b0;
  always @(posedge clk) rd_due <= cpu_sel && !cpu_wr && !reset;

  always @(negedge clk) begin
    if (vram_wr === 1'b1) mon_pop("vram_wr", {2'd1, vram_addr, vram_din});
    if (vram_rd === 1'b1) mon_pop("vram_rd", {2'd2, vram_addr, 8'h00});
    if (rd_due === 1'b1)  mon_pop("cpu_dout", {2'd3, 14'h0, cpu_dout});
  end

  // Reference model state.
  logic [7:0]  m_mem [0:16383];
  logic [7:0]  m_r [8];
  logic [13:0] m_addr;
  logic [7:0]  m_buf, m_lb;
  logic        m_latch, m_f, m_c, m_s5, m_tms_prev;
  logic [4:0]  m_s5n;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    m_addr = '0; m_buf = '0; m_lb = '0; m_latch = 1'b0;
    m_f = 1'b0; m_c = 1'b0; m_s5 = 1'b0; m_s5n = '0; m_tms_prev = 1'b0;
  endtask

  task automatic model_prefetch();
    exp_q.push_back({2'd2, m_addr, 8'h00});
    m_buf  = m_mem[m_addr];
    m_addr = m_addr + 14'd1;
  endtask

  task automatic model_cycle(input logic sel, input logic wr, input logic a0,
                             input logic [7:0] din, input logic fi);
    logic old_s5;
    logic [7:0] d;
    old_s5 = m_s5;
    if (sel && a0 && !wr) begin
      exp_q.push_back({2'd3, 14'h0, m_f, m_s5, m_c, m_s5n});
      m_f = 1'b0; m_c = 1'b0; m_s5 = 1'b0; m_latch = 1'b0;
    end
    if (fi) m_f = 1'b1;
    if (sprite_collision) m_c = 1'b1;
    if (too_many_sprites && !m_tms_prev) begin
      if (!old_s5) m_s5n = sprite5;
      m_s5 = 1'b1;
    end
    m_tms_prev = too_many_sprites;
    if (sel && a0 && wr) begin
      if (!m_latch) begin
        m_lb = din; m_latch = 1'b1;
      end else begin
        m_latch = 1'b0;
        if (din[7]) m_r[din & 8'h07] = m_lb;
        else begin
          m_addr = (din & 8'h3f) * 256 + m_lb;
          if (!din[6]) model_prefetch();
        end
      end
    end
    if (sel && !a0) begin
      m_latch = 1'b0;
      if (wr) begin
        exp_q.push_back({2'd1, m_addr, din});
        m_mem[m_addr] = din;
        m_buf  = din;
        m_addr = m_addr + 14'd1;
      end else begin
        d = m_buf;
        model_prefetch();
        exp_q.push_back({2'd3, 14'h0, d});
      end
    end
  endtask

  // Every driver task starts and ends just after a falling edge.
  task automatic step(input logic sel, input logic wr, input logic a0,
                      input logic [7:0] din, input logic fi);
    cpu_sel = sel; cpu_wr = wr; cpu_a0 = a0; cpu_din = din; frame_int = fi;
    model_cycle(sel, wr, a0, din, fi);
    @(posedge clk);
    @(negedge clk);
    cpu_sel = 1'b0; frame_int = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic ctrl(input logic [7:0] d);  step(1'b1, 1'b1, 1'b1, d, 1'b0); idle(); endtask
  task automatic dwr(input logic [7:0] d);   step(1'b1, 1'b1, 1'b0, d, 1'b0); idle(); endtask
  task automatic drd();                      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0); idle(); endtask
  task automatic srd();                      step(1'b1, 1'b0, 1'b1, 8'h00, 1'b0); idle(); endtask
  task automatic reg_wr(input logic [2:0] r, input logic [7:0] v);
    ctrl(v); ctrl({5'b10000, r});
  endtask

  task automatic do_reset();
    reset = 1'b1; cpu_sel = 1'b0; frame_int = 1'b0;
    sprite_collision = 1'b0; too_many_sprites = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_regs();
    logic [1:0] em;
    em = m_r[1][4] ? 2'd0 : m_r[0][1] ? 2'd2 : m_r[1][3] ? 2'd3 : 2'd1;
    chk("mode", mode, em);
    chk("name_tbl", name_table_addr, (m_r[2] % 16) * 1024);
    chk("color_tbl", color_table_addr, (em == 2'd2) ? (m_r[3] / 128) * 8192 : m_r[3] * 64);
    chk("font_tbl", font_table_addr,
        (em == 2'd2) ? ((m_r[4] / 4) % 2) * 8192 : (m_r[4] % 8) * 2048);
    chk("spr_attr_tbl", sprite_attr_table_addr, (m_r[5] % 128) * 128);
    chk("spr_pat_tbl", sprite_pattern_table_addr, (m_r[6] % 8) * 2048);
    chk("r1_bits", {video_on, vert_retrace_int, sprite_large, sprite_enlarged},
        {m_r[1][6], m_r[1][5], m_r[1][1], m_r[1][0]});
    chk("colors", {text_color, back_color}, m_r[7]);
    chk("n_int", n_int, !(m_f && m_r[1][5]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] v;
    int op, gap;
    for (int i = 0; i < 16384; i++) begin
      v = 8'($urandom);
      vmem[i] <= v;
      m_mem[i] = v;
    end
    vmem[14'h0123] <= 8'h5a;
    m_mem[14'h0123] = 8'h5a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    chk("reset_cpu_dout", cpu_dout, 8'h00);
    chk("reset_vram_pulses", {vram_wr, vram_rd}, 2'b00);
    chk("reset_mode", mode, 2'd1);
    chk("reset_n_int", n_int, 1'b1);
    check_regs();

    ctrl(8'h07); ctrl(8'h87);
    chk("r7_back", back_color, 4'h7);
    check_regs();

    ctrl(8'h00); ctrl(8'h40);
    dwr(8'haa); dwr(8'h55);
    drd();

    ctrl(8'h23); ctrl(8'h01);
    drd();
    idle(); drd();

    ctrl(8'hff); ctrl(8'h7f);
    dwr(8'h11);
    drd();

    reg_wr(3'd1, 8'h20);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("n_int_after_frame", n_int, 1'b0);
    srd();
    chk("n_int_after_status", n_int, 1'b1);
    srd();

    ctrl(8'h12); drd(); ctrl(8'h82);
    check_regs();
    ctrl(8'h40);

    sprite_collision = 1'b1; idle(); sprite_collision = 1'b0;
    sprite5 = 5'd13; too_many_sprites = 1'b1; idle();
    sprite5 = 5'd7; too_many_sprites = 1'b0; idle();
    too_many_sprites = 1'b1; idle();
    srd();
    step(1'b1, 1'b0, 1'b1, 8'h00, 1'b1); idle();
    srd();
    too_many_sprites = 1'b0;

    reg_wr(3'd0, 8'h02); check_regs();
    reg_wr(3'd3, 8'hff); reg_wr(3'd4, 8'h07); check_regs();
    reg_wr(3'd1, 8'h08); reg_wr(3'd0, 8'h00); check_regs();
    reg_wr(3'd1, 8'h53); reg_wr(3'd2, 8'h0f); check_regs();
    reg_wr(3'd5, 8'hff); reg_wr(3'd6, 8'hff); check_regs();

    ctrl(8'h34);
    do_reset();
    ctrl(8'h07); ctrl(8'h87);
    check_regs();
    ctrl(8'h00); ctrl(8'h01);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    do_reset();
    drd();
    check_regs();

    for (int it = 0; it < 400; it++) begin
      sprite_collision = ($urandom_range(0, 7) == 0);
      too_many_sprites = ($urandom_range(0, 3) == 0);
      sprite5 = 5'($urandom);
      op = $urandom_range(0, 5);
      case (op)
        0: reg_wr(3'($urandom), 8'($urandom));
        1: begin ctrl(8'($urandom)); ctrl({1'b0, 1'($urandom), 6'($urandom)}); end
        2: step(1'b1, 1'b1, 1'b0, 8'($urandom), ($urandom_range(0, 7) == 0));
        3: step(1'b1, 1'b0, 1'b0, 8'h00, ($urandom_range(0, 7) == 0));
        4: step(1'b1, 1'b0, 1'b1, 8'h00, ($urandom_range(0, 3) == 0));
        default: step(1'b1, 1'b1, 1'b1, 8'($urandom), 1'b0);
      endcase
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 8'h00, ($urandom_range(0, 9) == 0));
      if (it % 10 == 0) check_regs();
    end

    sprite_collision = 1'b0; too_many_sprites = 1'b0;
    repeat (4) idle();
    check_regs();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
